// File: rtl/tt_scanner_jdl25175_pkg.sv
// Shared types and constants for the truth-table scanner and its bench.
package tt_scanner_jdl25175_pkg;

  // Scanner FSM states, 2-bit binary encoding.
  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_DRIVE  = 2'd1,
    S_SAMPLE = 2'd2,
    S_DONE   = 2'd3
  } state_e;

  // Final truth-table index; the scan ends after this one is sampled.
  localparam logic [3:0] LAST_INDEX = 4'd15;

  // Width of the settle counter (SETTLE is limited to 1..15).
  localparam int CNT_W = 4;

  // Minterm accumulator step: adds one sampled f bit to the 5-bit count.
  function automatic logic [4:0] add_bit(input logic [4:0] acc, input logic b);
    return acc + {4'd0, b};
  endfunction

endpackage

// File: rtl/settle_timer_jdl25175.sv
// Settle counter: counts cycles while clear is low and flags when the
// count reaches SETTLE-1. Reusable by other stimulus stages.
module settle_timer_jdl25175
  import tt_scanner_jdl25175_pkg::*;
#(
  parameter int SETTLE = 1
) (
  input  logic clk,
  input  logic reset,
  input  logic clear,
  output logic expired
);

  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(SETTLE - 1);

  logic [CNT_W-1:0] cnt_q;
  logic [CNT_W-1:0] cnt_d;

  // Next count: restart on clear, otherwise advance by one.
  always_comb begin
    cnt_d = cnt_q + CNT_W'(1);
    if (clear) cnt_d = '0;
  end

  // Counter register with asynchronous reset.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) cnt_q <= '0;
    else       cnt_q <= cnt_d;
  end

  assign expired = (cnt_q == LAST_CNT);

endmodule

// File: rtl/tt_scanner_jdl25175.sv
// Truth-table scanner: walks abcd through 0..15, holds each vector for
// SETTLE+1 cycles, samples f on the last edge, and builds the 16-bit
// table plus its minterm count. All outputs are registered.
module tt_scanner_jdl25175
  import tt_scanner_jdl25175_pkg::*;
#(
  parameter int SETTLE = 1
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
  input  logic        f,
  output logic [3:0]  abcd,
  output logic        busy,
  output logic        done,
  output logic [15:0] tt_table,
  output logic [4:0]  ones
);

  state_e      state_q, state_d;
  logic [3:0]  idx_q, idx_d;
  logic [3:0]  abcd_q, abcd_d;
  logic        busy_q, busy_d;
  logic        done_q, done_d;
  logic [15:0] table_q, table_d;
  logic [4:0]  ones_q, ones_d;

  logic        tmr_clear;
  logic        tmr_expired;

  // The timer only runs while a vector is being held in DRIVE; it is
  // zeroed on the edge that leaves DRIVE and everywhere else.
  assign tmr_clear = (state_q != S_DRIVE) || tmr_expired;

  settle_timer_jdl25175 #(
    .SETTLE (SETTLE)
  ) u_timer (
    .clk     (clk),
    .reset   (reset),
    .clear   (tmr_clear),
    .expired (tmr_expired)
  );

  // Next-state, index, table insert and ones accumulation.
  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    abcd_d  = abcd_q;
    busy_d  = busy_q;
    done_d  = 1'b0;
    table_d = table_q;
    ones_d  = ones_q;
    unique case (state_q)
      S_IDLE: begin
        if (start) begin
          state_d = S_DRIVE;
          idx_d   = 4'd0;
          abcd_d  = 4'd0;
          table_d = 16'h0000;
          ones_d  = 5'd0;
          busy_d  = 1'b1;
        end
      end
      S_DRIVE: begin
        if (tmr_expired) state_d = S_SAMPLE;
      end
      S_SAMPLE: begin
        table_d[idx_q] = f;
        ones_d         = add_bit(ones_q, f);
        if (idx_q == LAST_INDEX) begin
          // Index check precedes the increment, so idx never wraps.
          state_d = S_DONE;
          busy_d  = 1'b0;
          done_d  = 1'b1;
        end else begin
          state_d = S_DRIVE;
          idx_d   = idx_q + 4'd1;
          abcd_d  = idx_q + 4'd1;
        end
      end
      S_DONE: begin
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  // State and output registers; reset discards any partial scan.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= S_IDLE;
      idx_q   <= 4'd0;
      abcd_q  <= 4'd0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      table_q <= 16'h0000;
      ones_q  <= 5'd0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      abcd_q  <= abcd_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
      table_q <= table_d;
      ones_q  <= ones_d;
    end
  end

  assign abcd     = abcd_q;
  assign busy     = busy_q;
  assign done     = done_q;
  assign tt_table = table_q;
  assign ones     = ones_q;

endmodule
